// File: rtl/puneh_mem_pkg.sv
// rtl/puneh_mem_pkg.sv - shared types, constants and parity helper for the PUNEH memory responder
// Contents: state_t (IDLE/WAIT/RESP), WAIT_CNT_W wait-counter width, even_parity() helper.
// Optional build macro used by the importing modules: PUNEH_MEM_PARITY_EN.
package puneh_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // Widest word the parity helper accepts; callers zero-extend, which
    // leaves the parity of the word unchanged.
    localparam int PAR_MAX_W = 64;

    // Even parity bit: stored bit plus data bits hold an even number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/puneh_mem_array.sv
// rtl/puneh_mem_array.sv - word RAM with synchronous write and combinational read
// Ports: clk; we/addr/wdata write port (written at rising edge); rdata combinational read of addr.
// With PUNEH_MEM_PARITY_EN: wpar stored alongside each word, rpar read back with rdata.
// Contents are never reset.
module puneh_mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
`ifdef PUNEH_MEM_PARITY_EN
    input  logic                  wpar,
    output logic                  rpar,
`endif
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

`ifdef PUNEH_MEM_PARITY_EN
    logic par_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[addr] <= wpar;
        end
    end

    assign rpar = par_mem[addr];
`endif

endmodule

// File: rtl/puneh_mem_responder.sv
// rtl/puneh_mem_responder.sv - wait-state memory responder serving single-word reads/writes
// Ports: clk, rst (sync active-high); addrBus/wdata/rd/wr request side from the datapath;
// rdata (to dataBusIn), ready (completion pulse), busy (transaction open), req_err (rd&wr pulse).
// Optional: PUNEH_MEM_PARITY_EN adds per-word parity storage and the par_err output.
module puneh_mem_responder
    import puneh_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addrBus,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              req_err
`ifdef PUNEH_MEM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam logic [WAIT_CNT_W-1:0] LAST_WAIT = WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                  state;
    state_t                  next_state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    op_wr_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    mem_we;
    logic                    start;
    logic                    strobe_held;

    // Only the low DEPTH_LOG2 address bits are decoded; the rest alias.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addrBus[ADDR_W-1:DEPTH_LOG2];

    assign start       = (state == IDLE) && (rd != wr);
    assign strobe_held = op_wr_q ? wr : rd;
    assign mem_we      = (state == RESP) && op_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            req_err <= 1'b0;
        end else begin
            state   <= next_state;
            req_err <= (state == IDLE) && rd && wr;
            if (start) begin
                addr_q  <= addrBus[DEPTH_LOG2-1:0];
                wdata_q <= wdata;
                op_wr_q <= wr;
                cnt     <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + WAIT_CNT_W'(1);
            end
            if ((state == RESP) && !op_wr_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // A dropped strobe aborts even on the last wait cycle.
                if (!strobe_held) begin
                    next_state = IDLE;
                end else if (cnt == LAST_WAIT) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    // Read data is visible in the ready cycle, then held in rdata_q.
    assign rdata = ((state == RESP) && !op_wr_q) ? mem_rdata : rdata_q;

`ifdef PUNEH_MEM_PARITY_EN
    logic mem_rpar;

    puneh_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .wpar  (even_parity(PAR_MAX_W'(wdata_q))),
        .rpar  (mem_rpar),
        .rdata (mem_rdata)
    );

    assign par_err = (state == RESP) && !op_wr_q &&
                     (even_parity(PAR_MAX_W'(mem_rdata)) != mem_rpar);
`else
    puneh_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );
`endif

endmodule

// File: tb/tb_puneh_mem_responder.sv
// tb/tb_puneh_mem_responder.sv - self-checking bench for puneh_mem_responder (WAIT_STATES 2 and 0)
module tb_puneh_mem_responder;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int DL   = 10;
    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_s    [2];
    logic [DW-1:0] wdata_s   [2];
    logic [DW-1:0] rdata_s   [2];
    logic          rd_s      [2];
    logic          wr_s      [2];
    logic          ready_s   [2];
    logic          busy_s    [2];
    logic          req_err_s [2];
`ifdef PUNEH_MEM_PARITY_EN
    logic          par_err_s [2];
`endif

    // Reference memory: one word per decoded address, per instance.
    logic [DW-1:0] model [2][1024];
    bit            known [2][1024];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    puneh_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .rst(rst), .addrBus(addr_s[0]), .wdata(wdata_s[0]), .rd(rd_s[0]), .wr(wr_s[0]),
        .rdata(rdata_s[0]), .ready(ready_s[0]), .busy(busy_s[0]), .req_err(req_err_s[0])
`ifdef PUNEH_MEM_PARITY_EN
        , .par_err(par_err_s[0])
`endif
    );

    puneh_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .rst(rst), .addrBus(addr_s[1]), .wdata(wdata_s[1]), .rd(rd_s[1]), .wr(wr_s[1]),
        .rdata(rdata_s[1]), .ready(ready_s[1]), .busy(busy_s[1]), .req_err(req_err_s[1])
`ifdef PUNEH_MEM_PARITY_EN
        , .par_err(par_err_s[1])
`endif
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? WS_A : WS_B;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete transaction; strobe dropped in the cycle ready is seen.
    task automatic txn(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input bit exp_perr);
        int idx;
        int lat;
        bit seen;
        idx = a % 1024;
        @(negedge clk);
        addr_s[k] = a; wdata_s[k] = d; rd_s[k] = !w; wr_s[k] = w;
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ready_s[k]) seen = 1;
            else check("busy_wait", 32'(busy_s[k]), 32'd1);
        end
        check(w ? "wr_latency" : "rd_latency", lat, ws_of(k) + 1);
        if (seen && !w && known[k][idx]) begin
            check("rd_data", 32'(rdata_s[k]), 32'(model[k][idx]));
`ifdef PUNEH_MEM_PARITY_EN
            check("par_err", 32'(par_err_s[k]), 32'(exp_perr));
`endif
        end
        rd_s[k] = 0; wr_s[k] = 0;
        if (w) begin
            model[k][idx] = d;
            known[k][idx] = 1;
        end
        @(negedge clk);
        check("ready_after", 32'(ready_s[k]), 32'd0);
        check("busy_after", 32'(busy_s[k]), 32'd0);
        if (!w && known[k][idx])
            check("rdata_hold", 32'(rdata_s[k]), 32'(model[k][idx]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d;
        for (int k = 0; k < 2; k++) begin
            addr_s[k] = '0; wdata_s[k] = '0; rd_s[k] = 0; wr_s[k] = 0;
            for (int i = 0; i < 1024; i++) known[k][i] = 0;
        end
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready_s[0]), 32'd0);
            check("idle_busy", 32'(busy_s[0]), 32'd0);
            check("idle_rdata", 32'(rdata_s[0]), 32'd0);
        end

        // WAIT_STATES=2 write then read
        txn(0, 1, 16'h0010, 16'hBEEF, 0);
        txn(0, 0, 16'h0010, 16'h0000, 0);

        // WAIT_STATES=0 back-to-back reads with strobe held
        txn(1, 1, 16'h0001, 16'hA1A1, 0);
        txn(1, 1, 16'h0002, 16'hB2B2, 0);
        @(negedge clk);
        addr_s[1] = 16'h0001; rd_s[1] = 1;
        @(negedge clk);
        check("b2b_ready1", 32'(ready_s[1]), 32'd1);
        check("b2b_data1", 32'(rdata_s[1]), 32'hA1A1);
        addr_s[1] = 16'h0002;
        @(negedge clk);
        check("b2b_gap", 32'(ready_s[1]), 32'd0);
        @(negedge clk);
        check("b2b_ready2", 32'(ready_s[1]), 32'd1);
        check("b2b_data2", 32'(rdata_s[1]), 32'hB2B2);
        rd_s[1] = 0;
        @(negedge clk);
        check("b2b_end", 32'(ready_s[1]), 32'd0);

        // Aliasing: 0x0410 decodes to the word at 0x0010
        txn(1, 1, 16'h0010, 16'h5A5A, 0);
        txn(1, 0, 16'h0410, 16'h0000, 0);

        // Abort: drop wr one cycle into WAIT
        txn(0, 1, 16'h0020, 16'h1111, 0);
        @(negedge clk);
        addr_s[0] = 16'h0020; wdata_s[0] = 16'h1234; wr_s[0] = 1;
        @(negedge clk);
        check("abort_busy", 32'(busy_s[0]), 32'd1);
        wr_s[0] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_ready", 32'(ready_s[0]), 32'd0);
            check("abort_busy_low", 32'(busy_s[0]), 32'd0);
        end
        txn(0, 0, 16'h0020, 16'h0000, 0);

        // Illegal rd&wr request
        @(negedge clk);
        rd_s[0] = 1; wr_s[0] = 1;
        @(negedge clk);
        check("req_err_hi", 32'(req_err_s[0]), 32'd1);
        check("req_err_ready", 32'(ready_s[0]), 32'd0);
        check("req_err_busy", 32'(busy_s[0]), 32'd0);
        rd_s[0] = 0; wr_s[0] = 0;
        @(negedge clk);
        check("req_err_lo", 32'(req_err_s[0]), 32'd0);

        // Reset mid-WAIT of a write
        @(negedge clk);
        addr_s[0] = 16'h0020; wdata_s[0] = 16'h7777; wr_s[0] = 1;
        @(negedge clk);
        rst = 1; wr_s[0] = 0;
        @(negedge clk);
        check("rst_busy", 32'(busy_s[0]), 32'd0);
        check("rst_ready", 32'(ready_s[0]), 32'd0);
        check("rst_rdata", 32'(rdata_s[0]), 32'd0);
        rst = 0;
        txn(0, 0, 16'h0020, 16'h0000, 0);

        // Randomized traffic on both instances with aliased addresses
        for (int i = 0; i < 60; i++) begin
            int k;
            int idx;
            bit w;
            k = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            a = 16'(int'($urandom_range(0, 63)) * 1024 + idx);
            d = 16'($urandom);
            w = ($urandom_range(0, 1) == 1) || !known[k][idx];
            txn(k, w, a, d, 0);
        end

`ifdef PUNEH_MEM_PARITY_EN
        txn(0, 1, 16'h0030, 16'h0003, 0);
        txn(0, 0, 16'h0030, 16'h0000, 0);
        @(negedge clk);
        dut_a.u_array.par_mem[10'h030] = ~dut_a.u_array.par_mem[10'h030];
        txn(0, 0, 16'h0030, 16'h0000, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/puneh_mem_responder.md
Name: puneh_mem_responder

Overview:
Word-addressed memory responder sitting on the far side of the PUNEH datapath's address/data buses. It accepts single-word read and write requests from the processor (address bus, outgoing data bus, read/write strobes) and serves them from an internal RAM. Programmable wait states are inserted before the response, and completion is signalled with a one-cycle `ready` handshake. It drives the processor's `dataBusIn`.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address bus width
DEPTH_LOG2, 10, log2 of RAM depth in words; only addrBus[DEPTH_LOG2-1:0] is decoded
WAIT_STATES, 2, idle cycles inserted between request capture and response (0..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
addrBus  in  ADDR_W  request address from datapath
wdata  in  DATA_W  write data (datapath dataBusOut)
rd  in  1  read request, held until ready
wr  in  1  write request, held until ready
rdata  out  DATA_W  read data to datapath dataBusIn
ready  out  1  one-cycle completion pulse
busy  out  1  transaction in progress
req_err  out  1  one-cycle pulse, illegal rd&wr request

Behaviour:
- Reset: state=IDLE, ready=0, busy=0, req_err=0, rdata=0, wait counter=0. RAM contents are not reset.
- States:
  - IDLE
  - WAIT: counter runs
  - RESP: ready asserted
- IDLE, exactly one of rd/wr high:
  - Capture address (low DEPTH_LOG2 bits), wdata and op.
  - busy=1.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- IDLE, rd and wr both high: no capture; req_err=1 next cycle; remain IDLE.
- WAIT:
  - Counter increments from 0; go to RESP when counter==WAIT_STATES-1.
  - If the captured op's strobe drops, the transaction aborts: go to IDLE, busy=0, no RAM write, no ready.
- RESP (one cycle):
  - ready=1.
  - Write: RAM[addr] updated at the end of this cycle.
  - Read: rdata loaded with RAM[addr] in the same cycle ready rises.
  - Next state is IDLE; busy=0 from the next cycle.
- rdata holds its value until the next completed read; writes and aborts do not change it.
- Latency: from the cycle the strobe is sampled in IDLE to ready = WAIT_STATES+1 cycles.
- Back-to-back: a strobe still high in the IDLE cycle after RESP starts a new transaction. The requester must drop the strobe in the cycle ready is seen, or it accepts a repeat access.
- Read-after-write to the same address in consecutive transactions returns the newly written data.
- Address aliasing: addresses differing only above bit DEPTH_LOG2-1 map to the same word.
- Reset asserted in any state returns to IDLE within one cycle; a pending write is discarded; ready is not issued.

Optional Feature:
PUNEH_MEM_PARITY_EN
- Defined:
  - RAM stores one extra even-parity bit per word, computed from wdata on write.
  - On read completion, recomputed parity is compared with the stored bit.
  - Mismatch sets output par_err (1 bit) for the ready cycle only; par_err resets to 0.
  - Port par_err exists only when the macro is defined.
- Undefined: no parity storage, no par_err port; behaviour otherwise identical.

Decomposition:
- Package puneh_mem_pkg:
  - state enum (IDLE, WAIT, RESP)
  - WAIT_CNT_W=4 constant
  - parity helper function
- Sub-module puneh_mem_array:
  - synchronous-write RAM, DEPTH_LOG2/DATA_W parameterised
  - combinational read port
  - parity bit width added under PUNEH_MEM_PARITY_EN
- FSM and counter stay in puneh_mem_responder.

Test Plan:
- Reset, then idle with rd=wr=0 -> ready=0, busy=0, rdata=16'h0000 for 10 cycles.
- WAIT_STATES=2: write 16'hBEEF to 16'h0010, then read 16'h0010 -> ready pulses 3 cycles after each strobe; rdata=16'hBEEF in the read's ready cycle.
- WAIT_STATES=0: back-to-back reads of 0x0001 and 0x0002 with strobe held -> ready every 2nd cycle with the correct data; alias check: a read of 16'h0410 (DEPTH_LOG2=10) returns the contents of 0x0010.
- Drop wr one cycle into WAIT during a write of 16'h1234 to 0x0020 -> no ready, busy falls; a later read of 0x0020 returns the old value.
- rd=wr=1 in IDLE -> req_err pulses for one cycle, no ready; rst asserted mid-WAIT of a write -> IDLE next cycle, RAM unchanged, rdata=0.
- With PUNEH_MEM_PARITY_EN: write 16'h0003, force the stored parity bit flipped, read back -> par_err=1 in the ready cycle; a clean word gives par_err=0.
